// File: rtl/ber_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// ber_sweep_ctrl_if
// Bundles the control, status and stimulus-count signals of the BER sweep
// controller. CLK and RST stay plain ports on the controller.
//
//   START      sweep request (level, sampled only in IDLE)
//   ABORT      sweep termination (level)
//   BASE_CTRL  default 31-bit control word (non-swept bits)
//   ERR_CNT    64-bit error count from the stimulus block
//   RECV_CNT   58-bit received-word count from the stimulus block
//   CTRL       registered control word to the DUT pads
//   CLR_SEQ    stimulus counter / PRBS clear
//   BUSY       high in every state except IDLE
//   DONE       one-cycle pulse at sweep end
//   CUR_IDX    current sweep point
//   PASS_MASK  bit i set when point i passed
//   BEST_IDX   point with the lowest error count
//   BEST_ERR   saturated error count of BEST_IDX
//
// Modports:
//   master  side that requests sweeps and supplies counts (UI / stimulus)
//   slave   the sweep controller itself
// -----------------------------------------------------------------------------
interface ber_sweep_ctrl_if;
   logic        START;
   logic        ABORT;
   logic [30:0] BASE_CTRL;
   logic [63:0] ERR_CNT;
   logic [57:0] RECV_CNT;
   logic [30:0] CTRL;
   logic        CLR_SEQ;
   logic        BUSY;
   logic        DONE;
   logic [3:0]  CUR_IDX;
   logic [15:0] PASS_MASK;
   logic [3:0]  BEST_IDX;
   logic [31:0] BEST_ERR;

   modport master (
      output START, ABORT, BASE_CTRL, ERR_CNT, RECV_CNT,
      input  CTRL, CLR_SEQ, BUSY, DONE, CUR_IDX, PASS_MASK, BEST_IDX, BEST_ERR
   );

   modport slave (
      input  START, ABORT, BASE_CTRL, ERR_CNT, RECV_CNT,
      output CTRL, CLR_SEQ, BUSY, DONE, CUR_IDX, PASS_MASK, BEST_IDX, BEST_ERR
   );
endinterface

// File: rtl/ber_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// ber_sweep_ctrl
// Automatic bit-error-rate sweep over the LVDS test-chip control word. Steps
// IDSET_A/B ([24:23]/[22:21]) and DRV_STR_A/B ([18:17]/[16:15]) through all
// 16 combinations. For each point: apply the word, settle, clear the stimulus
// counters, measure for a fixed window, then grade the error count.
//
// Ports:
//   CLK   system clock
//   RST   synchronous active-high reset
//   bus   ber_sweep_ctrl_if.slave (START/ABORT/BASE_CTRL/ERR_CNT/RECV_CNT in,
//         CTRL/CLR_SEQ/BUSY/DONE/CUR_IDX/PASS_MASK/BEST_IDX/BEST_ERR out)
//
// Parameters:
//   SETTLE_CYC  cycles spent settling per point (>=1)
//   MEAS_CYC    cycles spent measuring per point (>=1)
//   TMR_W       timer width, must hold max(SETTLE_CYC, MEAS_CYC)
//   ERR_TH      largest saturated error count still graded as pass
//
// Optional feature macro: BER_SWEEP_BEST_APPLY_EN
//   Defined: at sweep end CTRL is loaded with the best point's word and held
//   through IDLE until RST, ABORT or a new START.
//   Undefined: CTRL follows BASE_CTRL whenever the block is idle.
// -----------------------------------------------------------------------------
module ber_sweep_ctrl #(
   parameter int          SETTLE_CYC = 1024,
   parameter int          MEAS_CYC   = 65536,
   parameter int          TMR_W      = 20,
   parameter logic [31:0] ERR_TH     = 32'd0
) (
   input  logic           CLK,
   input  logic           RST,
   ber_sweep_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_CLEAR,
      S_MEAS,
      S_EVAL,
      S_FIN
   } state_t;

   state_t          state_q;
   logic [TMR_W-1:0] tmr_q;
   logic [30:0]     shadow_q;
   logic [30:0]     ctrl_q;
   logic            clr_q;
   logic            busy_q;
   logic            done_q;
   logic [3:0]      idx_q;
   logic [15:0]     pass_q;
   logic [3:0]      best_idx_q;
   logic [31:0]     best_err_q;
`ifdef BER_SWEEP_BEST_APPLY_EN
   logic            hold_q;   // CTRL frozen on the best word after a sweep
`endif

   // Grading of the current point
   logic [31:0] err_sat_d;    // 64-bit count saturated to 32 bits
   logic [31:0] err_rank_d;   // value used for best tracking
   logic        link_up_d;
   logic        pass_d;

   // Replace the swept fields of a control word with the given point index.
   function automatic logic [30:0] sweep_word(input logic [30:0] base,
                                              input logic [3:0]  idx);
      logic [30:0] w;
      w        = base;
      w[24:23] = idx[3:2];
      w[22:21] = idx[3:2];
      w[18:17] = idx[1:0];
      w[16:15] = idx[1:0];
      return w;
   endfunction

   always_comb begin
      // NOTE: every combinational output is given a value on every path so
      // no latch is inferred.
      err_sat_d  = (bus.ERR_CNT[63:32] != 32'd0) ? 32'hFFFF_FFFF : bus.ERR_CNT[31:0];
      link_up_d  = (bus.RECV_CNT != 58'd0);
      pass_d     = link_up_d && (err_sat_d <= ERR_TH);
      // A dead link must never look like a good point.
      err_rank_d = link_up_d ? err_sat_d : 32'hFFFF_FFFF;
   end

   always_ff @(posedge CLK) begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // sees the pre-edge values of all registers.
      if (RST) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         shadow_q   <= '0;
         ctrl_q     <= '0;
         clr_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         idx_q      <= 4'd0;
         pass_q     <= 16'd0;
         best_idx_q <= 4'd0;
         best_err_q <= 32'hFFFF_FFFF;
`ifdef BER_SWEEP_BEST_APPLY_EN
         hold_q     <= 1'b0;
`endif
      end else begin
         // CLR_SEQ and DONE are single-state pulses; set only on entry.
         clr_q  <= 1'b0;
         done_q <= 1'b0;

         if ((state_q != S_IDLE) && bus.ABORT) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`ifdef BER_SWEEP_BEST_APPLY_EN
            hold_q  <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_IDLE: begin
`ifdef BER_SWEEP_BEST_APPLY_EN
                  if (!hold_q || bus.START || bus.ABORT) begin
                     ctrl_q <= bus.BASE_CTRL;
                  end
                  if (bus.START || bus.ABORT) begin
                     hold_q <= 1'b0;
                  end
`else
                  ctrl_q <= bus.BASE_CTRL;
`endif
                  // ABORT has priority over START while idle.
                  if (bus.START && !bus.ABORT) begin
                     state_q    <= S_APPLY;
                     busy_q     <= 1'b1;
                     shadow_q   <= bus.BASE_CTRL;
                     idx_q      <= 4'd0;
                     pass_q     <= 16'd0;
                     best_idx_q <= 4'd0;
                     best_err_q <= 32'hFFFF_FFFF;
                  end
               end

               S_APPLY: begin
                  ctrl_q  <= sweep_word(shadow_q, idx_q);
                  tmr_q   <= TMR_W'(SETTLE_CYC - 1);
                  state_q <= S_SETTLE;
               end

               S_SETTLE: begin
                  if (tmr_q == '0) begin
                     state_q <= S_CLEAR;
                     clr_q   <= 1'b1;
                  end else begin
                     tmr_q <= tmr_q - 1'b1;
                  end
               end

               S_CLEAR: begin
                  tmr_q   <= TMR_W'(MEAS_CYC - 1);
                  state_q <= S_MEAS;
               end

               S_MEAS: begin
                  if (tmr_q == '0) begin
                     state_q <= S_EVAL;
                  end else begin
                     tmr_q <= tmr_q - 1'b1;
                  end
               end

               S_EVAL: begin
                  pass_q[idx_q] <= pass_d;
                  // Strict compare: on a tie the earlier (lower) index stays.
                  if (err_rank_d < best_err_q) begin
                     best_err_q <= err_rank_d;
                     best_idx_q <= idx_q;
                  end
                  if (idx_q == 4'd15) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     state_q <= S_APPLY;
                  end
               end

               S_FIN: begin
`ifdef BER_SWEEP_BEST_APPLY_EN
                  ctrl_q <= sweep_word(shadow_q, best_idx_q);
                  hold_q <= 1'b1;
`else
                  ctrl_q <= bus.BASE_CTRL;
`endif
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end

               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.CTRL      = ctrl_q;
   assign bus.CLR_SEQ   = clr_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.CUR_IDX   = idx_q;
   assign bus.PASS_MASK = pass_q;
   assign bus.BEST_IDX  = best_idx_q;
   assign bus.BEST_ERR  = best_err_q;

endmodule
